// File: rtl/imm_pkg.sv
// Shared immediate-format definitions for the encode and decode paths:
// select codes, field bit positions and range-check sign-bit indices.
package imm_pkg;

  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_U = 3'b011,
    IMM_J = 3'b100
  } imm_sel_e;

  // First select code that has no format; it and everything above are illegal.
  localparam logic [2:0] IMM_SEL_ILLEGAL = 3'b101;

  localparam int I_HI     = 31;
  localparam int I_LO     = 20;

  localparam int S_HI_HI  = 31;
  localparam int S_HI_LO  = 25;
  localparam int S_LO_HI  = 11;
  localparam int S_LO_LO  = 7;

  localparam int B_SIGN   = 31;
  localparam int B_B11    = 7;
  localparam int B_MID_HI = 30;
  localparam int B_MID_LO = 25;
  localparam int B_LO_HI  = 11;
  localparam int B_LO_LO  = 8;

  localparam int U_HI     = 31;
  localparam int U_LO     = 12;

  localparam int J_SIGN   = 31;
  localparam int J_HI_HI  = 19;
  localparam int J_HI_LO  = 12;
  localparam int J_B11    = 20;
  localparam int J_LO_HI  = 30;
  localparam int J_LO_LO  = 21;

  // Sign-bit index of the representable immediate for each signed format.
  localparam int IS_SBIT  = 11;
  localparam int B_SBIT   = 12;
  localparam int J_SBIT   = 20;

  function automatic logic sel_legal(input logic [2:0] sel);
    return sel < IMM_SEL_ILLEGAL;
  endfunction

endpackage

// File: rtl/imm_encoder_if.sv
// Request/response handshake bundle for imm_encoder; master drives requests
// and accepts results, slave is the encoder.
interface imm_encoder_if #(
  parameter int DWIDTH = 32,
  parameter int IWIDTH = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_sel;
  logic [DWIDTH-1:0] in_imm;
  logic [IWIDTH-1:0] in_base;
  logic              out_valid;
  logic              out_ready;
  logic [IWIDTH-1:0] out_inst;
  logic              out_err;

  modport master (
    output in_valid, in_sel, in_imm, in_base, out_ready,
    input  in_ready, out_valid, out_inst, out_err
  );

  modport slave (
    input  in_valid, in_sel, in_imm, in_base, out_ready,
    output in_ready, out_valid, out_inst, out_err
  );
endinterface

// File: rtl/imm_enc_core.sv
// Combinational immediate placement and range check. With
// IMMENC_PASSTHRU_ON_ERR_EN defined, erroneous words come out as the base word.
module imm_enc_core
  import imm_pkg::*;
#(
  parameter int DWIDTH = 32,
  parameter int IWIDTH = 32
) (
  input  logic [2:0]        i_sel,
  input  logic [DWIDTH-1:0] i_imm,
  input  logic [IWIDTH-1:0] i_base,
  output logic [IWIDTH-1:0] o_inst,
  output logic              o_err
);

  logic [IWIDTH-1:0] w_placed;
  logic              w_err;

  // True when every bit above sb matches bit sb, i.e. the value sign-extends from sb.
  function automatic logic upper_same(input logic [DWIDTH-1:0] v, input int sb);
    logic ok;
    ok = 1'b1;
    for (int k = 0; k < DWIDTH; k++) begin
      if (k > sb && v[k] != v[sb]) ok = 1'b0;
    end
    return ok;
  endfunction

  always_comb begin
    w_placed = i_base;
    w_err    = 1'b0;
    if (!sel_legal(i_sel)) begin
      w_err = 1'b1;
    end else begin
      case (i_sel)
        IMM_I: begin
          w_placed[I_HI:I_LO] = i_imm[11:0];
          w_err               = !upper_same(i_imm, IS_SBIT);
        end
        IMM_S: begin
          w_placed[S_HI_HI:S_HI_LO] = i_imm[11:5];
          w_placed[S_LO_HI:S_LO_LO] = i_imm[4:0];
          w_err                     = !upper_same(i_imm, IS_SBIT);
        end
        IMM_B: begin
          w_placed[B_SIGN]            = i_imm[12];
          w_placed[B_B11]             = i_imm[11];
          w_placed[B_MID_HI:B_MID_LO] = i_imm[10:5];
          w_placed[B_LO_HI:B_LO_LO]   = i_imm[4:1];
          w_err                       = !upper_same(i_imm, B_SBIT) || i_imm[0];
        end
        IMM_U: begin
          w_placed[U_HI:U_LO] = i_imm[31:12];
          w_err               = |i_imm[11:0];
        end
        IMM_J: begin
          w_placed[J_SIGN]          = i_imm[20];
          w_placed[J_HI_HI:J_HI_LO] = i_imm[19:12];
          w_placed[J_B11]           = i_imm[11];
          w_placed[J_LO_HI:J_LO_LO] = i_imm[10:1];
          w_err                     = !upper_same(i_imm, J_SBIT) || i_imm[0];
        end
        default: w_err = 1'b1;
      endcase
    end
  end

`ifdef IMMENC_PASSTHRU_ON_ERR_EN
  assign o_inst = w_err ? i_base : w_placed;
`else
  assign o_inst = w_placed;
`endif
  assign o_err = w_err;

endmodule

// File: rtl/imm_encoder.sv
// Two-stage valid/ready immediate encoder with saturating error counter.
// Optional build macro: IMMENC_PASSTHRU_ON_ERR_EN (erroneous words pass base through).
module imm_encoder
  import imm_pkg::*;
#(
  parameter int DWIDTH = 32,
  parameter int IWIDTH = 32,
  parameter int CNTW   = 16
) (
  input  logic            clk,
  input  logic            rst,
  imm_encoder_if.slave    bus,
  output logic [CNTW-1:0] err_count
);

  logic              r_vld_p1;
  logic [2:0]        r_sel_p1;
  logic [DWIDTH-1:0] r_imm_p1;
  logic [IWIDTH-1:0] r_base_p1;

  logic              r_vld_p2;
  logic [IWIDTH-1:0] r_inst_p2;
  logic              r_err_p2;
  logic [CNTW-1:0]   r_err_cnt;

  logic              w_s2_acc;
  logic              w_in_fire;
  logic              w_out_fire;
  logic [IWIDTH-1:0] w_inst;
  logic              w_err;

  // Gating with rst keeps the reset cycle free of any handshake transfer.
  assign w_s2_acc      = !r_vld_p2 || bus.out_ready;
  assign bus.in_ready  = !rst && (!r_vld_p1 || w_s2_acc);
  assign w_in_fire     = bus.in_valid && bus.in_ready;
  assign bus.out_valid = r_vld_p2 && !rst;
  assign w_out_fire    = bus.out_valid && bus.out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_p1  <= 1'b0;
      r_vld_p2  <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      if (bus.in_ready) r_vld_p1 <= bus.in_valid;
      if (w_s2_acc)     r_vld_p2 <= r_vld_p1;
      if (w_out_fire && r_err_p2 && r_err_cnt != '1)
        r_err_cnt <= r_err_cnt + CNTW'(1);
    end
  end

  // ---- stage 1: request capture ----
  always_ff @(posedge clk) begin
    if (w_in_fire) begin
      r_sel_p1  <= bus.in_sel;
      r_imm_p1  <= bus.in_imm;
      r_base_p1 <= bus.in_base;
    end
  end

  imm_enc_core #(
    .DWIDTH(DWIDTH),
    .IWIDTH(IWIDTH)
  ) u_core (
    .i_sel (r_sel_p1),
    .i_imm (r_imm_p1),
    .i_base(r_base_p1),
    .o_inst(w_inst),
    .o_err (w_err)
  );

  // ---- stage 2: encoded word, held while the consumer stalls ----
  always_ff @(posedge clk) begin
    if (rst) begin
      r_inst_p2 <= '0;
      r_err_p2  <= 1'b0;
    end else if (w_s2_acc && r_vld_p1) begin
      r_inst_p2 <= w_inst;
      r_err_p2  <= w_err;
    end
  end

  assign bus.out_inst = r_inst_p2;
  assign bus.out_err  = r_err_p2;
  assign err_count    = r_err_cnt;

endmodule

// File: tb/tb_imm_encoder.sv
// Directed plus random bench for imm_encoder with a queue scoreboard; a second
// instance with a 2-bit counter shares the stimulus to exercise saturation.
module tb_imm_encoder;

  logic        clk;
  logic        rst;
  logic [15:0] err16;
  logic [1:0]  err2;

  imm_encoder_if #(.DWIDTH(32), .IWIDTH(32)) bus ();
  imm_encoder_if #(.DWIDTH(32), .IWIDTH(32)) bus2 ();

  assign bus2.in_valid  = bus.in_valid;
  assign bus2.in_sel    = bus.in_sel;
  assign bus2.in_imm    = bus.in_imm;
  assign bus2.in_base   = bus.in_base;
  assign bus2.out_ready = bus.out_ready;

  imm_encoder #(.DWIDTH(32), .IWIDTH(32), .CNTW(16)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave), .err_count(err16)
  );
  imm_encoder #(.DWIDTH(32), .IWIDTH(32), .CNTW(2)) dut_sat (
    .clk(clk), .rst(rst), .bus(bus2.slave), .err_count(err2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef IMMENC_PASSTHRU_ON_ERR_EN
  localparam bit PT = 1'b1;
`else
  localparam bit PT = 1'b0;
`endif

  typedef struct {
    logic [31:0] inst;
    logic        err;
  } exp_t;

  exp_t        q[$];
  exp_t        pend;
  int          total = 0;
  int          bad = 0;
  int          cnt = 0;
  int          nout = 0;
  bit          accepted = 0;
  bit          rnd_rdy = 0;
  bit          stall_prev = 0;
  logic [31:0] prev_inst;
  logic        prev_err;

  function automatic logic [63:0] satv(input int c, input int w);
    longint m;
    m = (64'sd1 <<< w) - 1;
    return (c > m) ? 64'(m) : 64'(c);
  endfunction

  // Reference encoder written with whole-word concatenations and numeric ranges.
  function automatic logic [32:0] model(input logic [2:0] sel, input logic [31:0] imm,
                                        input logic [31:0] base);
    logic [31:0] w;
    logic        e;
    int          s;
    s = int'($signed(imm));
    case (sel)
      3'd0: begin w = {imm[11:0], base[19:0]}; e = (s < -2048 || s > 2047); end
      3'd1: begin w = {imm[11:5], base[24:12], imm[4:0], base[6:0]}; e = (s < -2048 || s > 2047); end
      3'd2: begin
        w = {imm[12], imm[10:5], base[24:12], imm[4:1], imm[11], base[6:0]};
        e = (s < -4096 || s > 4095 || imm[0]);
      end
      3'd3: begin w = {imm[31:12], base[11:0]}; e = (imm[11:0] != 12'd0); end
      3'd4: begin
        w = {imm[20], imm[10:1], imm[11], imm[19:12], base[11:0]};
        e = (s < -1048576 || s > 1048575 || imm[0]);
      end
      default: begin w = base; e = 1'b1; end
    endcase
    if (PT && e) w = base;
    return {e, w};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample at the falling edge, then return 1ns after the rising edge.
  task automatic cycle();
    exp_t e;
    if (rnd_rdy) bus.out_ready = 1'($urandom_range(0, 1));
    @(negedge clk);
    chk("err_count", 64'(err16), satv(cnt, 16));
    chk("err_count_sat", 64'(err2), satv(cnt, 2));
    chk("twin_valid", 64'(bus2.out_valid), 64'(bus.out_valid));
    accepted = 1'b0;
    if (!rst) begin
      if (bus.out_valid && !bus.out_ready && stall_prev) begin
        chk("hold_inst", 64'(bus.out_inst), 64'(prev_inst));
        chk("hold_err", 64'(bus.out_err), 64'(prev_err));
      end
      stall_prev = bus.out_valid && !bus.out_ready;
      prev_inst  = bus.out_inst;
      prev_err   = bus.out_err;
      if (bus.out_valid && bus.out_ready) begin
        nout++;
        total++;
        assert (q.size() != 0) else begin
          bad++;
          $error("FAIL extra_output observed=%0h expected=none", bus.out_inst);
        end
        if (q.size() != 0) begin
          e = q.pop_front();
          chk("out_inst", 64'(bus.out_inst), 64'(e.inst));
          chk("out_err", 64'(bus.out_err), 64'(e.err));
          if (e.err) cnt++;
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        accepted = 1'b1;
        q.push_back(pend);
      end
    end else begin
      stall_prev = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [2:0] sel, input logic [31:0] imm, input logic [31:0] base,
                         input logic [31:0] einst, input logic eerr);
    bus.in_valid = 1'b1;
    bus.in_sel   = sel;
    bus.in_imm   = imm;
    bus.in_base  = base;
    pend.inst    = einst;
    pend.err     = eerr;
  endtask

  task automatic wait_accept(input string tag);
    accepted = 1'b0;
    for (int k = 0; k < 50 && !accepted; k++) cycle();
    total++;
    assert (accepted) else begin
      bad++;
      $error("FAIL %s observed=not_accepted expected=accepted", tag);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic send(input logic [2:0] sel, input logic [31:0] imm, input logic [31:0] base,
                      input logic [31:0] einst, input logic eerr);
    set_req(sel, imm, base, einst, eerr);
    wait_accept("accept");
  endtask

  task automatic send_m(input logic [2:0] sel, input logic [31:0] imm, input logic [31:0] base);
    logic [32:0] r;
    r = model(sel, imm, base);
    send(sel, imm, base, r[31:0], r[32]);
  endtask

  task automatic drain();
    bus.out_ready = 1'b1;
    for (int k = 0; k < 50 && q.size() != 0; k++) cycle();
    total++;
    assert (q.size() == 0) else begin
      bad++;
      $error("FAIL drain observed=%0d expected=0", q.size());
    end
  endtask

  initial begin
    int          n0;
    logic [31:0] ri;
    logic [2:0]  rs;
    logic [32:0] mr;

    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_sel    = 3'd0;
    bus.in_imm    = 32'd0;
    bus.in_base   = 32'd0;
    bus.out_ready = 1'b1;
    repeat (2) cycle();
    rst = 1'b0;
    #1;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_inst", 64'(bus.out_inst), 64'd0);
    chk("rst_out_err", 64'(bus.out_err), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);

    // Latency: nothing visible one edge after acceptance, result on the next.
    send(3'd0, 32'hFFFF_FFFF, 32'h0000_0093, 32'hFFF0_0093, 1'b0);
    chk("lat_early_valid", 64'(bus.out_valid), 64'd0);
    cycle();
    chk("lat_valid", 64'(bus.out_valid), 64'd1);
    chk("lat_inst", 64'(bus.out_inst), 64'hFFF0_0093);

    send(3'd1, 32'd8,  32'h0020_A023, 32'h0020_A423, 1'b0);
    send(3'd2, 32'd16, 32'h0000_0063, 32'h0000_0863, 1'b0);
    send(3'd4, 32'h800, 32'h0000_00EF, 32'h0010_00EF, 1'b0);
    send(3'd4, 32'h801, 32'h0000_00EF, PT ? 32'h0000_00EF : 32'h0010_00EF, 1'b1);
    drain();
    chk("cnt_after_j", 64'(err16), 64'd1);

    send(3'd0, 32'h800, 32'h0000_0013, PT ? 32'h0000_0013 : 32'h8000_0013, 1'b1);
    send(3'd6, 32'd5,   32'h0000_0013, 32'h0000_0013, 1'b1);
    send(3'd0, 32'h7FF, 32'h0000_0013, 32'h7FF0_0013, 1'b0);
    send(3'd0, 32'hFFFF_F800, 32'h0000_0013, 32'h8000_0013, 1'b0);
    send(3'd3, 32'h1234_5000, 32'h0000_0037, 32'h1234_5037, 1'b0);
    send(3'd3, 32'h1234_5001, 32'h0000_0037, PT ? 32'h0000_0037 : 32'h1234_5037, 1'b1);
    send(3'd2, 32'd3, 32'h0000_0063, PT ? 32'h0000_0063 : 32'h0000_0163, 1'b1);
    drain();
    chk("cnt_five", 64'(err16), 64'd5);
    chk("cnt_sat", 64'(err2), 64'd3);

    // Backpressure: two requests fill the pipe, the third must stall.
    n0 = nout;
    bus.out_ready = 1'b0;
    mr = model(3'd0, 32'd1, 32'h13);
    set_req(3'd0, 32'd1, 32'h13, mr[31:0], mr[32]);
    cycle();
    chk("bp_acc0", 64'(accepted), 64'd1);
    mr = model(3'd1, 32'd2, 32'h23);
    set_req(3'd1, 32'd2, 32'h23, mr[31:0], mr[32]);
    cycle();
    chk("bp_acc1", 64'(accepted), 64'd1);
    mr = model(3'd2, 32'd4, 32'h63);
    set_req(3'd2, 32'd4, 32'h63, mr[31:0], mr[32]);
    chk("bp_in_ready_low", 64'(bus.in_ready), 64'd0);
    repeat (3) begin
      cycle();
      chk("bp_no_accept", 64'(accepted), 64'd0);
    end
    bus.out_ready = 1'b1;
    wait_accept("bp_acc2");
    send_m(3'd3, 32'h0000_3000, 32'h37);
    drain();
    chk("bp_outputs", 64'(nout - n0), 64'd4);

    // Random traffic with random consumer stalls.
    rnd_rdy = 1'b1;
    for (int i = 0; i < 40; i++) begin
      rs = 3'($urandom_range(0, 7));
      ri = ($urandom_range(0, 1) == 1) ? 32'($urandom) : 32'($urandom_range(0, 8191)) - 32'd4096;
      send_m(rs, ri, 32'($urandom));
    end
    rnd_rdy = 1'b0;
    drain();

    // Reset with two requests in flight.
    bus.out_ready = 1'b0;
    send_m(3'd0, 32'h900, 32'h13);
    send_m(3'd4, 32'h3, 32'hEF);
    rst = 1'b1;
    cycle();
    q.delete();
    cnt = 0;
    stall_prev = 1'b0;
    rst = 1'b0;
    #1;
    chk("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("mid_rst_err_count", 64'(err16), 64'd0);
    chk("mid_rst_err_sat", 64'(err2), 64'd0);
    chk("mid_rst_in_ready", 64'(bus.in_ready), 64'd1);
    bus.out_ready = 1'b1;
    repeat (3) cycle();
    chk("mid_rst_quiet", 64'(bus.out_valid), 64'd0);
    send(3'd1, 32'hFFFF_FFFF, 32'h0000_0023, 32'hFE00_0FA3, 1'b0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imm_encoder.md
Name: imm_encoder

Overview:
- Pipelined immediate encoder: inverse of the immediate decode path.
- Takes a 32-bit immediate, a format select and a base instruction word (opcode/rd/rs/funct already set), and scatters the immediate into the format's instruction bit positions.
- Range-checks the immediate and flags violations.
- Sits in the instruction patch/self-test generator ahead of the instruction memory write port; valid/ready on both sides.

Parameters:
- DWIDTH, 32, immediate width in bits.
- IWIDTH, 32, instruction width in bits.
- CNTW, 16, width of the saturating error counter.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  request valid
- in_ready  output  1  encoder can accept a request this cycle
- in_sel  input  3  format: 000 I, 001 S, 010 B, 011 U, 100 J, 101-111 illegal
- in_imm  input  DWIDTH  signed immediate (byte offset for B/J)
- in_base  input  IWIDTH  instruction word; bits outside the immediate field pass through unchanged
- out_valid  output  1  encoded word valid
- out_ready  input  1  downstream accepts
- out_inst  output  IWIDTH  encoded instruction
- out_err  output  1  range/alignment/select violation for out_inst
- err_count  output  CNTW  saturating count of delivered words with out_err=1

Behaviour:
- Field placement:
  - I: inst[31:20]=imm[11:0].
  - S: inst[31:25]=imm[11:5]; inst[11:7]=imm[4:0].
  - B: inst[31]=imm[12]; inst[7]=imm[11]; inst[30:25]=imm[10:5]; inst[11:8]=imm[4:1].
  - U: inst[31:12]=imm[31:12].
  - J: inst[31]=imm[20]; inst[19:12]=imm[19:12]; inst[20]=imm[11]; inst[30:21]=imm[10:1].
  - All other bits come from in_base.
- Error rules (out_err=1 if any holds):
  - I/S: imm[31:11] not all equal (not a 12-bit signed value).
  - B: imm[31:12] not all equal, or imm[0]=1.
  - J: imm[31:20] not all equal, or imm[0]=1.
  - U: imm[11:0] != 0.
  - in_sel in 101-111: out_inst=in_base.
- On an out-of-range immediate, the low bits are still encoded (truncated); only out_err signals the violation.
- Pipeline:
  - Two registered stages. S1 captures in_sel, in_imm and in_base. S2 holds the encoded out_inst and out_err; encoding and range check are combinational between S1 and S2.
  - Each stage advances when it is empty or the next stage is accepting.
  - in_ready = !s1_valid || s2_accepting, combinational with no same-stage loop.
  - Latency: a request accepted at edge N gives out_valid at edge N+2 if unstalled.
  - Throughput: 1 per cycle while out_ready=1.
- Handshake:
  - Transfer occurs when valid && ready on a rising edge.
  - While out_valid && !out_ready, out_inst and out_err hold stable.
  - A full pipeline drops in_ready the same cycle out_ready is low.
  - No request is lost or duplicated.
- err_count: increments on each output transfer with out_err=1; saturates at all-ones and does not wrap.
- Reset values: s1_valid=0, out_valid=0, out_inst=0, out_err=0, err_count=0. in_ready=1 in the first cycle after reset.
- Reset mid-operation: in-flight requests are discarded and no output transfer occurs in the reset cycle.

Optional Feature:
- Macro: IMMENC_PASSTHRU_ON_ERR_EN.
- Defined: any word with out_err=1 is emitted as in_base unmodified, with no partial immediate bits.
- Undefined: truncated encoding per the placement rules above.
- out_err and err_count behave identically in both builds.

Decomposition:
- Shared package imm_pkg:
  - ImmSel codes IMM_I/IMM_S/IMM_B/IMM_U/IMM_J, shared with the decode side.
  - Field bit-position constants.
  - Illegal-select constant.
- One sub-module, imm_enc_core: combinational placement plus range check, instantiated between S1 and S2.
- The top level owns the pipeline registers, handshake and counter.

Test Plan:
- I-type: sel=000, base=0x00000093, imm=0xFFFFFFFF -> out_inst=0xFFF00093, out_err=0, two cycles after acceptance.
- S-type: sel=001, base=0x0020A023, imm=8 -> 0x0020A423. B-type: sel=010, base=0x00000063, imm=16 -> 0x00000863. All with out_err=0.
- J-type: sel=100, base=0x000000EF, imm=0x800 -> 0x001000EF. Then imm=0x801 -> out_err=1 and err_count increments to 1.
- Range: sel=000, imm=0x800 -> out_err=1. Undefined build: out_inst=base|0x80000000. Defined build: out_inst=base. sel=110 -> out_err=1, out_inst=base.
- Backpressure: 4 back-to-back requests, out_ready held low 5 cycles -> in_ready low after 2 accepted; out_inst stable throughout; on release all 4 appear in order; no loss or duplication.
- Saturation and reset: CNTW=2, 5 erroneous transfers -> err_count=3. rst asserted with 2 requests in flight -> out_valid=0 the next cycle, err_count=0, in_ready=1.
